// File: rtl/hex8_loader.sv
// Boot loader for the hex8 core: receives SYNC/LEN/payload/CSUM frames, writes the payload
// from address 0 and releases the core once the checksum verifies. HEX8_LOADER_RELOAD_EN enables hot reload.
module hex8_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       core_reset,
    output logic       load_done,
    output logic       err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] CSUM  = 3'd3;
    localparam logic [2:0] RUN   = 3'd4;
    localparam logic [2:0] ERROR = 3'd5;

    logic [2:0] state;
    logic [8:0] remaining;
    logic [7:0] acc;
    logic [7:0] addr;
    logic [7:0] csum_total;
    logic       accept;
    logic       is_sync;

`ifdef HEX8_LOADER_RELOAD_EN
    assign in_ready = reset;
`else
    assign in_ready = reset && (state != RUN);
`endif

    assign accept     = in_valid && in_ready;
    assign is_sync    = (in_data == SYNC_BYTE);
    assign csum_total = acc + in_data;

    // Status outputs decode the state directly, so reset drives them to their idle values.
    assign core_reset = (state != RUN);
    assign load_done  = (state == RUN);
    assign err        = (state == ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            addr      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (is_sync) state <= LEN;
                    end
                    LEN: begin
                        remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        acc       <= '0;
                        addr      <= '0;
                        state     <= DATA;
                    end
                    DATA: begin
                        acc       <= csum_total;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + 8'd1;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) state <= CSUM;
                    end
                    CSUM: begin
                        state <= (csum_total == 8'h00) ? RUN : ERROR;
                    end
                    RUN: begin
`ifdef HEX8_LOADER_RELOAD_EN
                        if (is_sync) state <= LEN;
`endif
                    end
                    ERROR: begin
                        if (is_sync) state <= LEN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex8_loader.sv
// Self-checking bench for hex8_loader: directed frames plus randomized frames checked
// against a frame-level model (payload image and modular checksum rule).
module tb_hex8_loader;

    localparam logic [7:0] SYNC = 8'hA5;
`ifdef HEX8_LOADER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_reset;
    logic       load_done;
    logic       err;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned wr_count = 0;
    int unsigned cr_run = 0;
    logic [7:0]  dut_mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  pl [$];

    hex8_loader #(.SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset(core_reset), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    // Program memory as the hex8 core would see it, plus core_reset run length.
    always @(negedge clk) begin
        if (mem_we) begin
            dut_mem[mem_addr] = mem_wdata;
            wr_count = wr_count + 1;
        end
        if (core_reset) cr_run = cr_run + 1;
        else cr_run = 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        int unsigned w0 = wr_count;
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = SYNC;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_core_reset", 32'(core_reset), 32'd1);
            check("rst_load_done", 32'(load_done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
            check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            @(posedge clk); #1;
        end
        check("rst_no_writes", wr_count - w0, 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_noise(input logic [7:0] b);
        int unsigned w0 = wr_count;
        send_byte(b);
        check("noise_we", 32'(mem_we), 32'd0);
        check("noise_writes", wr_count - w0, 32'd0);
    endtask

    // gap_mode: 0 none, 1 random 0..3 idle cycles between payload bytes, 2 four idle cycles before byte 1.
    task automatic run_frame(input logic [7:0] c, input int unsigned gap_mode, output bit ok);
        int unsigned n = pl.size();
        int unsigned sum = 0;
        int unsigned w0 = wr_count;
        int unsigned g;
        logic [8:0] n9 = 9'(n);
        send_byte(SYNC);
        check("sync_core_reset", 32'(core_reset), 32'd1);
        check("sync_load_done", 32'(load_done), 32'd0);
        check("sync_err", 32'(err), 32'd0);
        send_byte(n9[7:0]);
        check("len_we", 32'(mem_we), 32'd0);
        for (int i = 0; i < int'(n); i++) begin
            g = 0;
            if (gap_mode == 1 && i > 0) g = $urandom_range(0, 3);
            if (gap_mode == 2 && i == 1) g = 4;
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk); #1;
                    check("gap_we", 32'(mem_we), 32'd0);
                end
            end
            send_byte(pl[i]);
            check("wr_we", 32'(mem_we), 32'd1);
            check("wr_addr", 32'(mem_addr), 32'(i % 256));
            check("wr_data", 32'(mem_wdata), 32'(pl[i]));
            ref_mem[i % 256] = pl[i];
            sum += pl[i];
        end
        ok = ((sum + c) % 256) == 0;
        send_byte(c);
        in_valid = 1'b0;
        check("csum_we", 32'(mem_we), 32'd0);
        check("csum_core_reset", 32'(core_reset), 32'(!ok));
        check("csum_load_done", 32'(load_done), 32'(ok));
        check("csum_err", 32'(err), 32'(!ok));
        check("frame_writes", wr_count - w0, n);
        if (ok) check("core_reset_held3", 32'(cr_run >= 3), 32'd1);
        for (int i = 0; i < int'(n) && i < 256; i++)
            check("mem_image", 32'(dut_mem[i]), 32'(ref_mem[i]));
        if (ok && !RELOAD) check("run_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        bit ok;
        bit last_ok;
        int unsigned len;
        logic [7:0] c;
        logic [7:0] b;
        int unsigned sum;

        do_reset();

        // Good frame with a sync value inside the payload.
        pl = '{8'hA5, 8'h10};
        run_frame(8'h4B, 0, ok);
        if (!RELOAD) begin
            in_valid = 1'b1;
            in_data  = SYNC;
            repeat (3) begin
                @(posedge clk); #1;
                check("run_stall_we", 32'(mem_we), 32'd0);
                check("run_stall_done", 32'(load_done), 32'd1);
            end
            in_valid = 1'b0;
        end else begin
            // Hot reload straight from RUN.
            pl = '{8'h77};
            run_frame(8'h89, 0, ok);
        end

        do_reset();
        pl = '{8'h33};
        run_frame(8'h00, 0, ok);
        repeat (2) begin
            @(posedge clk); #1;
            check("err_hold", 32'(err), 32'd1);
            check("err_core_reset", 32'(core_reset), 32'd1);
        end
        send_noise(8'h42);
        check("err_after_noise", 32'(err), 32'd1);
        run_frame(8'hCD, 0, ok);

        // Length 0 means 256 bytes; the address counter wraps.
        do_reset();
        pl = {};
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        run_frame(8'h80, 0, ok);

        // Noise, then a stalled frame.
        do_reset();
        send_noise(8'h00);
        send_noise(8'hFF);
        send_noise(8'h5A);
        pl = '{8'h11, 8'h22};
        run_frame(8'hCD, 2, ok);

        // Reset mid-payload.
        do_reset();
        send_byte(SYNC);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_core_reset", 32'(core_reset), 32'd1);
        check("midrst_load_done", 32'(load_done), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        do_reset();
        send_noise(8'h05);
        send_noise(8'h03);

        // Randomized frames against the checksum/image model.
        last_ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (last_ok && !RELOAD) do_reset();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                send_noise(b);
            end
            len = $urandom_range(1, 20);
            pl = {};
            sum = 0;
            for (int i = 0; i < int'(len); i++) begin
                b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
                pl.push_back(b);
                sum += b;
            end
            c = 8'((256 - (sum % 256)) % 256);
            if ($urandom_range(0, 2) == 0) c = c + 8'($urandom_range(1, 255));
            run_frame(c, 1, ok);
            last_ok = ok;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
